bram_arbiter: RTL and testbench

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arb_pkg.sv | 14 +
 rtl/bram_arbiter_rr_arb2.sv | 17 +
 rtl/bram_arbiter.sv | 103 ++++++++++
 tb/tb_bram_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared defaults and FSM state type for the BRAM arbiter.
//   ADDR_W_DFLT / DATA_W_DFLT / NREQ_DFLT : default geometry
//   state_e                                 : CLEAR (zero sweep) / RUN (arbitrate)
`timescale 1ns/1ps
package bram_arb_pkg;
    localparam int ADDR_W_DFLT = 10;
    localparam int DATA_W_DFLT = 32;
    localparam int NREQ_DFLT   = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;
endpackage

// File: rtl/bram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
//   valid[1:0] : requests
//   ptr        : requester that wins when both are valid
//   grant[1:0] : one-hot winner, zero when nothing is valid
`timescale 1ns/1ps
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);
    always_comb begin
        grant = valid;                   // a lone requester always wins
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port BRAM between two requesters.
// After reset the whole BRAM is swept with zeros (CLEAR), then requests are
// granted round-robin (RUN). Read data returns one cycle after the grant,
// tagged with the owner held in a 1-deep in-flight register.
// Ports:
//   clk, rstn                      : clock, async active-low reset
//   req_valid/ready/we/addr/wdata  : per-requester request channel
//   rsp_valid[NREQ], rsp_rdata     : per-requester read strobe, shared data
//   bram_en/we/addr/din, bram_dout : BRAM port (1-cycle read latency)
//   init_done                      : high once the clear sweep is finished
`timescale 1ns/1ps
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT,
    parameter int NREQ   = NREQ_DFLT
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0]              req_we,
    input  logic [NREQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         bram_en,
    output logic                         bram_we,
    output logic [ADDR_W-1:0]            bram_addr,
    output logic [DATA_W-1:0]            bram_din,
    input  logic [DATA_W-1:0]            bram_dout,
    output logic                         init_done
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ptr_q, ptr_d;
    logic [NREQ-1:0]   rd_own_q, rd_own_d;
    logic [NREQ-1:0]   grant;
    logic              win;

    rr_arb2 u_rr (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // grant is one-hot, so its upper bit is the winner's index
    assign win = grant[1];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ptr_d     = ptr_q;
        rd_own_d  = '0;
        req_ready = '0;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = req_addr[win];
        bram_din  = req_wdata[win];
        case (state_q)
            CLEAR: begin
                bram_en   = 1'b1;
                bram_we   = 1'b1;
                bram_addr = clr_cnt_q;
                bram_din  = '0;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                req_ready = grant;
                if (|grant) begin
                    bram_en  = 1'b1;
                    bram_we  = req_we[win];
                    ptr_d    = ~win;
                    // only reads leave a response owner behind
                    rd_own_d = req_we[win] ? '0 : grant;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            ptr_q     <= 1'b0;
            rd_own_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ptr_q     <= ptr_d;
            rd_own_q  <= rd_own_d;
        end
    end

    assign rsp_valid = rd_own_q;
    assign rsp_rdata = bram_dout;
    assign init_done = (state_q == RUN);
endmodule

// File: tb/tb_bram_arbiter.sv
`timescale 1ns/1ps
module tb_bram_arbiter;
    logic              clk = 1'b0;
    logic              rstn;
    logic [1:0]        req_valid, req_ready, req_we, rsp_valid;
    logic [1:0][9:0]   req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [31:0]       rsp_rdata, bram_din;
    logic [31:0]       bram_dout = 32'h0;
    logic              bram_en, bram_we, init_done;
    logic [9:0]        bram_addr;

    always #5 clk = ~clk;

    bram_arbiter #(.ADDR_W(10), .DATA_W(32), .NREQ(2)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout), .init_done(init_done)
    );

    // BRAM environment: registered read, garbage content before the sweep
    logic [31:0] bram_mem [1024];
    initial for (int i = 0; i < 1024; i++) bram_mem[i] = $urandom;
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_din;
            else         bram_dout <= bram_mem[bram_addr];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: clear sweep as an address count, round-robin as
    // "who goes next", memory as a plain array, response as the value due next cycle.
    bit          m_clear = 1'b1;
    int          m_cnt = 0;
    int          m_next = 0;
    logic [1:0]  m_rsp = 2'b00;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_mem [1024];

    always @(negedge clk) begin : model
        int w;
        if (!rstn) begin
            chk("m_rst_ready", 64'(req_ready), 64'(0));
            chk("m_rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("m_rst_init_done", 64'(init_done), 64'(0));
            m_clear = 1'b1; m_cnt = 0; m_next = 0; m_rsp = 2'b00;
        end else if (m_clear) begin
            chk("m_clr_ready", 64'(req_ready), 64'(0));
            chk("m_clr_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("m_clr_init_done", 64'(init_done), 64'(0));
            chk("m_clr_en_we", 64'({bram_en, bram_we}), 64'(3));
            chk("m_clr_addr", 64'(bram_addr), 64'(m_cnt));
            chk("m_clr_din", 64'(bram_din), 64'(0));
            m_mem[m_cnt] = 32'h0;
            if (m_cnt == 1023) m_clear = 1'b0;
            m_cnt++;
        end else begin
            w = -1;
            if (req_valid == 2'b11)  w = m_next;
            else if (req_valid[0])   w = 0;
            else if (req_valid[1])   w = 1;
            chk("m_init_done", 64'(init_done), 64'(1));
            chk("m_rsp_valid", 64'(rsp_valid), 64'(m_rsp));
            if (m_rsp != 2'b00) chk("m_rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
            chk("m_ready", 64'(req_ready), (w < 0) ? 64'(0) : 64'(1) << w);
            chk("m_en", 64'(bram_en), 64'(w >= 0));
            if (w < 0) begin
                chk("m_we_idle", 64'(bram_we), 64'(0));
                m_rsp = 2'b00;
            end else begin
                chk("m_we", 64'(bram_we), 64'(req_we[w]));
                chk("m_addr", 64'(bram_addr), 64'(req_addr[w]));
                if (req_we[w]) chk("m_din", 64'(bram_din), 64'(req_wdata[w]));
                m_next = 1 - w;
                if (req_we[w]) begin
                    m_mem[req_addr[w]] = req_wdata[w];
                    m_rsp = 2'b00;
                end else begin
                    m_rsp   = 2'b01 << w;
                    m_rdata = m_mem[req_addr[w]];
                end
            end
        end
    end

    typedef struct packed {
        logic [1:0] v;
        logic [1:0] we;
        logic [1:0] rdy;
        logic       en;
        logic       bwe;
        logic [9:0] addr;
        logic [1:0] rsp;
    } vec_t;
    vec_t tbl [9];

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        @(posedge clk); #1;
        req_valid = v; req_we = we;
        req_addr[0] = a0; req_addr[1] = a1;
        req_wdata[0] = d0; req_wdata[1] = d1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0; req_valid = 2'b00;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    // returns the 1-based cycle after reset release in which init_done is first seen
    task automatic wait_init(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!init_done && cyc < 3000);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cyc;
        logic [1:0] hs;
        rstn = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        tbl[0] = '{v:2'b11, we:2'b00, rdy:2'b01, en:1'b1, bwe:1'b0, addr:10'h010, rsp:2'b00};
        tbl[1] = '{v:2'b11, we:2'b11, rdy:2'b10, en:1'b1, bwe:1'b1, addr:10'h020, rsp:2'b01};
        tbl[2] = '{v:2'b10, we:2'b00, rdy:2'b10, en:1'b1, bwe:1'b0, addr:10'h020, rsp:2'b00};
        tbl[3] = '{v:2'b00, we:2'b00, rdy:2'b00, en:1'b0, bwe:1'b0, addr:10'h000, rsp:2'b10};
        tbl[4] = '{v:2'b01, we:2'b01, rdy:2'b01, en:1'b1, bwe:1'b1, addr:10'h010, rsp:2'b00};
        tbl[5] = '{v:2'b11, we:2'b00, rdy:2'b10, en:1'b1, bwe:1'b0, addr:10'h020, rsp:2'b00};
        tbl[6] = '{v:2'b11, we:2'b00, rdy:2'b01, en:1'b1, bwe:1'b0, addr:10'h010, rsp:2'b10};
        tbl[7] = '{v:2'b01, we:2'b00, rdy:2'b01, en:1'b1, bwe:1'b0, addr:10'h010, rsp:2'b01};
        tbl[8] = '{v:2'b00, we:2'b00, rdy:2'b00, en:1'b0, bwe:1'b0, addr:10'h000, rsp:2'b01};

        // clear sweep length after the initial reset
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        wait_init(cyc);
        chk("init_done_cycle", 64'(cyc), 64'(1025));

        // both reading back-to-back from a fresh pointer
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b00, 10'h001, 10'h002, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("rr_ready_%0d", i), 64'(req_ready), (i % 2 == 0) ? 64'(1) : 64'(2));
            chk($sformatf("rr_rsp_%0d", i), 64'(rsp_valid),
                (i == 0) ? 64'(0) : ((i % 2 == 1) ? 64'(1) : 64'(2)));
        end
        drive(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rr_rsp_tail", 64'(rsp_valid), 64'(2));

        // table-driven arbitration vectors
        for (int r = 0; r < 9; r++) begin
            drive(tbl[r].v, tbl[r].we, 10'h010, 10'h020, 32'hA000_0000 + r, 32'hB000_0000 + r);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
            chk($sformatf("tbl%0d_en", r), 64'(bram_en), 64'(tbl[r].en));
            chk($sformatf("tbl%0d_we", r), 64'(bram_we), 64'(tbl[r].bwe));
            if (tbl[r].en) chk($sformatf("tbl%0d_addr", r), 64'(bram_addr), 64'(tbl[r].addr));
            chk($sformatf("tbl%0d_rsp", r), 64'(rsp_valid), 64'(tbl[r].rsp));
        end

        // top address reads back as cleared
        drive(2'b01, 2'b00, 10'h3FF, 10'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("top_rd_ready", 64'(req_ready), 64'(1));
        drive(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("top_rd_rsp", 64'(rsp_valid), 64'(1));
        chk("top_rd_data", 64'(rsp_rdata), 64'(0));

        // write by r0 then immediate read by r1 of the same address
        drive(2'b01, 2'b01, 10'h155, 10'h0, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        chk("wr_ready", 64'(req_ready), 64'(1));
        drive(2'b10, 2'b00, 10'h0, 10'h155, 32'h0, 32'h0);
        @(negedge clk);
        chk("raw_ready", 64'(req_ready), 64'(2));
        chk("raw_no_wr_rsp", 64'(rsp_valid), 64'(0));
        drive(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("raw_rsp", 64'(rsp_valid), 64'(2));
        chk("raw_data", 64'(rsp_rdata), 64'(32'hDEADBEEF));

        // lone r1 streams reads with no bubble
        for (int i = 0; i < 5; i++) begin
            drive(2'b10, 2'b00, 10'h0, 10'h155, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("lone_ready_%0d", i), 64'(req_ready), 64'(2));
            chk($sformatf("lone_rsp_%0d", i), 64'(rsp_valid), (i == 0) ? 64'(0) : 64'(2));
        end
        drive(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("lone_rsp_tail", 64'(rsp_valid), 64'(2));

        // random traffic, requests held until accepted; the model checks every cycle
        hs = 2'b00;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (hs[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    req_we[i]    = 1'($urandom_range(0, 1));
                    req_addr[i]  = 10'($urandom_range(0, 15));
                    req_wdata[i] = $urandom;
                end
            end
            @(negedge clk);
            hs = req_valid & req_ready;
        end
        drive(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        @(negedge clk);

        // request raised during the sweep waits for the first RUN cycle
        do_reset();
        cyc = 1;
        while (cyc < 3000) begin
            @(negedge clk);
            if (init_done) break;
            if (cyc >= 10) chk("clr_hold_ready", 64'(req_ready), 64'(0));
            @(posedge clk); #1;
            cyc++;
            if (cyc == 10) begin
                req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 10'h3FF;
            end
        end
        chk("clr_req_first_run", 64'(req_ready), 64'(1));
        chk("clr_req_cycle", 64'(cyc), 64'(1025));
        drive(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("clr_req_rsp", 64'(rsp_valid), 64'(1));
        chk("clr_req_data", 64'(rsp_rdata), 64'(0));

        // reset right after a read handshake drops the response
        drive(2'b01, 2'b00, 10'h155, 10'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_hs_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        rstn = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        chk("rst_drop_rsp", 64'(rsp_valid), 64'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_rel_rsp", 64'(rsp_valid), 64'(0));
        chk("rst_rel_addr", 64'(bram_addr), 64'(0));
        chk("rst_rel_we", 64'(bram_we), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
